// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage floating-point multiplier with a valid bit per
// pipeline slot, one global advance enable, round-to-nearest-even and sticky
// overflow/exception flags.
//
// Handshake: an operand pair is accepted on every rising clk edge where
// reset=1, en=1 and in_valid=1. There is no ready signal. en=0 freezes every
// register, so the source must hold off issuing until en returns. out_valid
// marks the cycle in which result and the per-result flags belong to one
// accepted operation. While en=0 out_valid is held, so a consumer counts a
// result only on an edge where en=1.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int N     = EXP_W + MAN_W + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         in_valid,
  input  logic [N-1:0] inputA,
  input  logic [N-1:0] inputB,
  input  logic         clr_flags,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         overflow,
  output logic         underflow,
  output logic         exception,
  output logic         sticky_ovf,
  output logic         sticky_exc
);

  localparam int PW = 2 * MAN_W + 2;  // full product width
  localparam int EW = EXP_W + 2;      // signed working exponent width
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS     = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic signed [EW-1:0] EXP_MAX  = {2'b00, {EXP_W{1'b1}}};
  localparam logic [N-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand field decode; exponent 0 (zero or denormal) is flushed to zero.
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sign = inputA[N-1];
  assign b_sign = inputB[N-1];
  assign a_exp  = inputA[N-2 -: EXP_W];
  assign b_exp  = inputB[N-2 -: EXP_W];
  assign a_frac = inputA[MAN_W-1:0];
  assign b_frac = inputB[MAN_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

  // Stage 1 registers: unpacked operands with hidden bit and class bits.
  logic             s1_valid, s1_sign_a, s1_sign_b;
  logic [EXP_W-1:0] s1_exp_a, s1_exp_b;
  logic [MAN_W:0]   s1_man_a, s1_man_b;
  logic             s1_zero_a, s1_zero_b, s1_inf_a, s1_inf_b, s1_nan_a, s1_nan_b;

  // Stage 1: capture decoded operands when the pipe advances.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_sign_a <= 1'b0;
      s1_sign_b <= 1'b0;
      s1_exp_a  <= '0;
      s1_exp_b  <= '0;
      s1_man_a  <= '0;
      s1_man_b  <= '0;
      s1_zero_a <= 1'b0;
      s1_zero_b <= 1'b0;
      s1_inf_a  <= 1'b0;
      s1_inf_b  <= 1'b0;
      s1_nan_a  <= 1'b0;
      s1_nan_b  <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sign_a <= a_sign;
      s1_sign_b <= b_sign;
      s1_exp_a  <= a_exp;
      s1_exp_b  <= b_exp;
      s1_man_a  <= a_zero ? '0 : {1'b1, a_frac};
      s1_man_b  <= b_zero ? '0 : {1'b1, b_frac};
      s1_zero_a <= a_zero;
      s1_zero_b <= b_zero;
      s1_inf_a  <= a_inf;
      s1_inf_b  <= b_inf;
      s1_nan_a  <= a_nan;
      s1_nan_b  <= b_nan;
    end
  end

  // Stage 2 registers: raw product, sign, unbiased exponent sum, special case.
  logic                 s2_valid, s2_sign, s2_nan, s2_inf, s2_zero;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;

  // Stage 2: multiply mantissas and classify special operand combinations.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_inf   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_prod  <= '0;
      s2_exp   <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign_a ^ s1_sign_b;
      s2_nan   <= s1_nan_a | s1_nan_b | (s1_inf_a & s1_zero_b) | (s1_inf_b & s1_zero_a);
      s2_inf   <= s1_inf_a | s1_inf_b;
      s2_zero  <= s1_zero_a | s1_zero_b;
      s2_prod  <= PW'(s1_man_a) * PW'(s1_man_b);
      s2_exp   <= $signed({2'b00, s1_exp_a}) + $signed({2'b00, s1_exp_b}) - BIAS;
    end
  end

  // Stage 3 datapath: normalise, round to nearest even, range check, pack.
  logic [PW-1:0]        norm;
  logic [MAN_W:0]       kept;
  logic                 guard_bit, sticky_bit, round_up, carry;
  logic [MAN_W+1:0]     rounded;
  logic [MAN_W-1:0]     frac_f;
  logic signed [EW-1:0] exp_f;
  logic [N-1:0]         nxt_result;
  logic                 nxt_ovf, nxt_unf, nxt_exc;

  // Combinational normalise/round and special-case result selection.
  always_comb begin
    norm       = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    kept       = norm[PW-1 -: MAN_W+1];
    guard_bit  = norm[MAN_W];
    sticky_bit = |norm[MAN_W-1:0];
    round_up   = guard_bit & (sticky_bit | kept[0]);
    rounded    = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
    carry      = rounded[MAN_W+1];
    frac_f     = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    exp_f      = s2_exp + {{(EW-1){1'b0}}, s2_prod[PW-1]} + {{(EW-1){1'b0}}, carry};
    nxt_result = {s2_sign, exp_f[EXP_W-1:0], frac_f};
    nxt_ovf    = 1'b0;
    nxt_unf    = 1'b0;
    nxt_exc    = 1'b0;
    if (s2_nan) begin
      nxt_result = QNAN;
      nxt_exc    = 1'b1;
    end else if (s2_inf) begin
      nxt_result = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      nxt_exc    = 1'b1;
    end else if (s2_zero) begin
      nxt_result = {s2_sign, {(N-1){1'b0}}};
    end else if (exp_f >= EXP_MAX) begin
      nxt_result = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
      nxt_ovf    = 1'b1;
    end else if (exp_f <= 0) begin
      nxt_result = {s2_sign, {(N-1){1'b0}}};
      nxt_unf    = 1'b1;
    end
    // Flags of an empty slot are forced low so they never reach the stickies.
    nxt_ovf = nxt_ovf & s2_valid;
    nxt_unf = nxt_unf & s2_valid;
    nxt_exc = nxt_exc & s2_valid;
  end

  // Stage 3: output registers; clearing loads the incoming flags directly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      exception  <= 1'b0;
      sticky_ovf <= 1'b0;
      sticky_exc <= 1'b0;
    end else if (en) begin
      out_valid  <= s2_valid;
      result     <= nxt_result;
      overflow   <= nxt_ovf;
      underflow  <= nxt_unf;
      exception  <= nxt_exc;
      sticky_ovf <= clr_flags ? nxt_ovf : (sticky_ovf | nxt_ovf);
      sticky_exc <= clr_flags ? nxt_exc : (sticky_exc | nxt_exc);
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vectors for fp_mult_pipe with hand-computed
// products, an in-order expected queue for every accepted operation, and
// explicit timing checks for latency, stall, clear and reset behaviour.
module tb_fp_mult_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int N     = EXP_W + MAN_W + 1;
  localparam int W     = N + 3;  // {result, overflow, underflow, exception}

  logic         clk = 1'b0;
  logic         reset, en, in_valid, clr_flags;
  logic [N-1:0] inputA, inputB;
  logic         out_valid, overflow, underflow, exception, sticky_ovf, sticky_exc;
  logic [N-1:0] result;

  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic         adv;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .inputA     (inputA),
    .inputB     (inputB),
    .clr_flags  (clr_flags),
    .out_valid  (out_valid),
    .result     (result),
    .overflow   (overflow),
    .underflow  (underflow),
    .exception  (exception),
    .sticky_ovf (sticky_ovf),
    .sticky_exc (sticky_exc)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Drive one operation for one advancing edge and queue its expected output.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] res, input logic ovf,
                       input logic unf, input logic exc);
    inputA   = a;
    inputB   = b;
    in_valid = 1'b1;
    exp_q.push_back({res, ovf, unf, exc});
    step();
    in_valid = 1'b0;
  endtask

  // Record whether the last edge advanced the pipe.
  always @(posedge clk) adv = en & reset;

  // Scoreboard: every advancing edge with out_valid consumes one expectation.
  always @(negedge clk) begin : scoreboard
    logic [W-1:0] e;
    if (adv && out_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("result_flags", 64'({result, overflow, underflow, exception}), 64'(e));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b1; in_valid = 1'b0; clr_flags = 1'b0;
    inputA = '0; inputB = '0;
    steps(2);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", 64'(result), 64'd0);
    check_eq("rst_flags", 64'({overflow, underflow, exception, sticky_ovf, sticky_exc}), 64'd0);
    reset = 1'b1;
    step();

    // Latency: 2.0 * 3.0 appears after the third advancing edge only.
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
    check_eq("lat_edge1", 64'(out_valid), 64'd0);
    step();
    check_eq("lat_edge2", 64'(out_valid), 64'd0);
    step();
    check_eq("lat_edge3", 64'(out_valid), 64'd1);
    check_eq("lat_result", 64'(result), 64'h40C00000);
    check_eq("lat_flags", 64'({overflow, underflow, exception}), 64'd0);
    step();
    check_eq("lat_edge4", 64'(out_valid), 64'd0);

    // Back-to-back rounding cases, two consecutive valid cycles.
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0, 0);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0);
    check_eq("b2b_pre", 64'(out_valid), 64'd0);
    step();
    check_eq("b2b_first", 64'(out_valid), 64'd1);
    step();
    check_eq("b2b_second", 64'(out_valid), 64'd1);
    step();
    check_eq("b2b_after", 64'(out_valid), 64'd0);

    // Streamed vectors: ties, rounding carry, sign, zero, range boundaries.
    issue(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 0, 0, 0);  // tie, odd -> up
    issue(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 0, 0, 0);  // tie, even -> stay
    issue(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 0, 0, 0);  // round carry-out
    issue(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 0, 0, 0);  // below half
    issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0);  // negative
    issue(32'h80000000, 32'h40400000, 32'h80000000, 0, 0, 0);  // -0 x finite
    issue(32'h00000001, 32'h40000000, 32'h00000000, 0, 0, 0);  // denormal flushed
    issue(32'h7F000000, 32'h3F800000, 32'h7F000000, 0, 0, 0);  // largest exponent
    issue(32'h00800000, 32'h3F800000, 32'h00800000, 0, 0, 0);  // smallest exponent
    issue(32'h00800000, 32'h3F000000, 32'h00000000, 0, 1, 0);  // exponent hits 0
    steps(3);
    check_eq("sticky_ovf_quiet", 64'(sticky_ovf), 64'd0);

    // Overflow and sticky overflow behaviour.
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0);
    steps(2);
    check_eq("ovf_flag", 64'(overflow), 64'd1);
    check_eq("sticky_ovf_set", 64'(sticky_ovf), 64'd1);
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
    steps(3);
    check_eq("sticky_ovf_hold", 64'(sticky_ovf), 64'd1);
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_eq("sticky_ovf_clr", 64'(sticky_ovf), 64'd0);
    issue(32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0, 0);  // exponent exactly all-ones
    step();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_eq("sticky_clr_prio", 64'(sticky_ovf), 64'd1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check_eq("sticky_clr_idle", 64'(sticky_ovf), 64'd0);
    check_eq("sticky_exc_quiet", 64'(sticky_exc), 64'd0);

    // Exceptions and underflow.
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000, 0, 0, 1);  // inf x 0
    steps(2);
    check_eq("exc_flag", 64'(exception), 64'd1);
    check_eq("sticky_exc_set", 64'(sticky_exc), 64'd1);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, 0, 0, 1);  // -inf x finite
    issue(32'h7F800001, 32'h3F800000, 32'h7FC00000, 0, 0, 1);  // NaN input
    issue(32'h00000000, 32'h7FC00000, 32'h7FC00000, 0, 0, 1);  // 0 x NaN
    issue(32'hFF800000, 32'h7F800000, 32'hFF800000, 0, 0, 1);  // -inf x inf
    issue(32'h80800000, 32'h00800000, 32'h80000000, 0, 1, 0);  // underflow
    steps(2);
    check_eq("unf_flag", 64'(underflow), 64'd1);
    check_eq("unf_result", 64'(result), 64'h80000000);
    step();

    // Stall mid-flight: outputs frozen, then remaining results in order.
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
    issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0, 0);
    issue(32'hC0000000, 32'h40400000, 32'hC0C00000, 0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("frz_valid", 64'(out_valid), 64'd1);
      check_eq("frz_result", 64'(result), 64'h40C00000);
    end
    en = 1'b1;
    steps(2);
    check_eq("frz_last", 64'(result), 64'hC0C00000);
    step();
    check_eq("frz_drained", 64'(out_valid), 64'd0);

    // Reset with two operations in flight while stalled.
    issue(32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 0);
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 1, 0, 0);
    en = 1'b0;
    reset = 1'b0;
    step();
    exp_q.delete();
    reset = 1'b1;
    en = 1'b1;
    check_eq("rstm_out_valid", 64'(out_valid), 64'd0);
    check_eq("rstm_result", 64'(result), 64'd0);
    check_eq("rstm_flags", 64'({overflow, underflow, exception, sticky_ovf, sticky_exc}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rstm_no_valid", 64'(out_valid), 64'd0);
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Parametrised, pipelined IEEE-754-style floating-point multiplier with a valid-tagged datapath, global stall, round-to-nearest-even and sticky status flags. It is the successor of the single-register-stage 32-bit multiplier wrapper: exponent and mantissa widths are generic, and each pipeline slot carries its own valid bit. It sits between operand-issue logic and a result consumer that may stall the pipe.

Parameters:
EXP_W, 8, exponent field width in bits (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored mantissa (fraction) width in bits
N, EXP_W+MAN_W+1, total word width (derived; not overridden independently)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
en  input  1  pipeline advance; 0 freezes every stage register including flags
in_valid  input  1  operands on inputA/inputB are valid this cycle
inputA  input  N  operand A {sign, exponent, fraction}
inputB  input  N  operand B
clr_flags  input  1  clears sticky flags (honoured only when en=1)
out_valid  output  1  result/overflow/exception/underflow valid
result  output  N  product
overflow  output  1  per-result overflow
underflow  output  1  per-result underflow (flushed to zero)
exception  output  1  per-result invalid/special-operand flag
sticky_ovf  output  1  OR of overflow over all valid results since reset/clear
sticky_exc  output  1  OR of exception over all valid results since reset/clear

Behaviour:
- Reset (reset=0 at a clk edge): all stage valids, out_valid, result, overflow, underflow, exception, sticky_ovf and sticky_exc go to 0. Reset overrides en. Operations in flight are discarded.
- Three stages, latency 3 advancing cycles. S1 registers unpacked operands and in_valid. S2 registers the (MAN_W+1)x(MAN_W+1) product, sign XOR, and exponent sum minus bias, with EXP_W+2 bit signed width. S3 normalises, rounds, packs and drives the outputs.
- en=0: no register changes; outputs hold their values and out_valid holds. There is no back-pressure beyond en; the upstream source must not assume acceptance while en=0.
- in_valid=0 still advances the stage but marks it invalid. Flags on invalid slots are 0 and do not touch the sticky flags.
- Sign = signA XOR signB in all cases, including zero and inf results.
- Zero/denormal input: exponent==0 is treated as signed zero (flush-to-zero on input).
- Normalisation: if product bit 2*MAN_W+1 is set, shift right 1 and exponent+1.
- Rounding: round-to-nearest, ties-to-even, using guard bit plus OR of the remaining bits. A mantissa carry-out on rounding increments the exponent.
- Overflow: final biased exponent >= 2^EXP_W-1 → result = signed infinity, overflow=1.
- Underflow: final biased exponent <= 0 with nonzero operands → result = signed zero, underflow=1.
- Exception (checked first; it overrides overflow and underflow):
  - Either input NaN → result = canonical quiet NaN {0, all-ones exp, MSB fraction 1, rest 0}, exception=1.
  - inf x zero → canonical quiet NaN, exception=1.
  - inf x finite-nonzero → signed infinity, exception=1, overflow=0.
- Zero x finite → signed zero, all flags 0.
- Sticky flags:
  - On an en=1 edge with clr_flags=1, the sticky flags become exactly the flags of the result entering S3 this edge (clear has priority over the old value).
  - Otherwise they OR in that result's flags when it is valid.
- Back-to-back issue: one operation accepted per advancing cycle, no bubbles required.

Test Plan:
- Default params, in_valid=1 for one cycle, A=0x40000000 (2.0), B=0x40400000 (3.0), en=1 → out_valid=1 exactly 3 edges later, result=0x40C00000, all flags 0, out_valid=0 next cycle.
- A=B=0x3F800001 → result=0x3F800002 (round-nearest). Then A=B=0x3FC00000 → 0x40100000, issued back-to-back: two consecutive out_valid cycles in order.
- A=B=0x7F000000 → result=0x7F800000, overflow=1, sticky_ovf=1 and staying 1. Then clr_flags=1 with a clean op → sticky_ovf=0.
- A=0x7F800000, B=0x00000000 → result=0x7FC00000, exception=1, sticky_exc=1. Separately, A=0x80800000, B=0x00800000 → result=0x80000000, underflow=1.
- Issue 3 ops, hold en=0 for 5 cycles mid-flight → outputs frozen, no valid lost or duplicated; after release, results emerge in issue order.
- reset=0 for one edge with 2 ops in flight and en=0 → next cycle all outputs 0, and no out_valid ever appears for the discarded ops.
